// File: rtl/ex_iter_unit_pkg.sv
// ---------------------------------------------------------------------------
// ex_iter_unit_pkg
// Shared constants for the execute-stage iterative unit:
//   - EXE_*_OP   : 8-bit operation codes coming from decode
//   - EXE_RES_*  : 3-bit result-class selectors
//   - div_state_e: state encoding of the iterative divider
//   - is_div_op(): true for the two multi-cycle divide opcodes
// ---------------------------------------------------------------------------
package ex_iter_unit_pkg;

    // Logic operations
    localparam logic [7:0] EXE_NOP_OP  = 8'b0000_0000;
    localparam logic [7:0] EXE_AND_OP  = 8'b0010_0100;
    localparam logic [7:0] EXE_OR_OP   = 8'b0010_0101;
    localparam logic [7:0] EXE_XOR_OP  = 8'b0010_0110;
    localparam logic [7:0] EXE_NOR_OP  = 8'b0010_0111;

    // Shift / rotate operations
    localparam logic [7:0] EXE_SLL_OP  = 8'b0111_1100;
    localparam logic [7:0] EXE_SRL_OP  = 8'b0000_0010;
    localparam logic [7:0] EXE_SRA_OP  = 8'b0000_0011;
    localparam logic [7:0] EXE_ROR_OP  = 8'b0000_0101;

    // Multi-cycle divide operations
    localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

    // Result classes
    localparam logic [2:0] EXE_RES_NOP   = 3'b000;
    localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
    localparam logic [2:0] EXE_RES_SHIFT = 3'b010;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    function automatic logic is_div_op(input logic [7:0] op);
        return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP);
    endfunction

endpackage

// File: rtl/ex_iter_unit_if.sv
// ---------------------------------------------------------------------------
// ex_iter_unit_if
// Bundles the decode-side inputs and writeback-side outputs of ex_iter_unit.
//   master : the pipeline driving decode fields and consuming results
//   slave  : the execute unit itself
// Inputs : aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i, annul_i
// Outputs: wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o
// ---------------------------------------------------------------------------
interface ex_iter_unit_if #(
    parameter int WIDTH = 32
);
    logic [7:0]       aluop_i;
    logic [2:0]       alusel_i;
    logic [WIDTH-1:0] reg1_i;
    logic [WIDTH-1:0] reg2_i;
    logic [4:0]       wd_i;
    logic             wreg_i;
    logic             annul_i;

    logic [4:0]       wd_o;
    logic             wreg_o;
    logic [WIDTH-1:0] wdata_o;
    logic             whilo_o;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;
    logic             stallreq_o;

    modport master (
        output aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i, annul_i,
        input  wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o
    );

    modport slave (
        input  aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i, annul_i,
        output wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o
    );
endinterface

// File: rtl/ex_iter_unit_div_iter.sv
// ---------------------------------------------------------------------------
// div_iter
// Restoring radix-2 divider producing one quotient bit per clock.
//   clk, rst      : clock, synchronous active-high reset
//   start_i       : divide op present this cycle
//   annul_i       : flush; abandons BUSY/DONE and blocks a start
//   signed_i      : 1 = signed divide, 0 = unsigned
//   dividend_i    : dividend operand
//   divisor_i     : divisor operand
//   state_o       : current FSM state (used by the parent for stalling)
//   done_o        : one-cycle result strobe
//   quotient_o    : quotient, valid with done_o (0 otherwise)
//   remainder_o   : remainder, valid with done_o (0 otherwise)
// ---------------------------------------------------------------------------
module div_iter
    import ex_iter_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             annul_i,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output div_state_e       state_o,
    output logic             done_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o
);

    localparam logic [SHW:0] LAST_CNT = (SHW+1)'(WIDTH - 1);

    div_state_e       state_q, state_d;
    logic [SHW:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0] dq_q, dq_d;       // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] rem_q, rem_d;     // partial remainder
    logic [WIDTH-1:0] dvs_q, dvs_d;     // divisor magnitude
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;

    logic [WIDTH-1:0] dividend_mag;
    logic [WIDTH-1:0] divisor_mag;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;
    logic             fits;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] dq_step;

    assign dividend_mag = (signed_i && dividend_i[WIDTH-1]) ? -dividend_i : dividend_i;
    assign divisor_mag  = (signed_i && divisor_i[WIDTH-1])  ? -divisor_i  : divisor_i;

    // The partial remainder is always below the divisor, so one extra bit
    // is enough for the trial subtraction; its MSB is the borrow.
    assign trial    = {rem_q, dq_q[WIDTH-1]};
    assign diff     = trial - {1'b0, dvs_q};
    assign fits     = ~diff[WIDTH];
    assign rem_step = fits ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
    assign dq_step  = {dq_q[WIDTH-2:0], fits};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dq_d      = dq_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        lo_d      = lo_q;
        hi_d      = hi_q;

        unique case (state_q)
            DIV_IDLE: begin
                if (start_i && !annul_i) begin
                    if (divisor_i == '0) begin
                        lo_d    = '1;
                        hi_d    = dividend_i;
                        state_d = DIV_DONE;
                    end else begin
                        dq_d      = dividend_mag;
                        rem_d     = '0;
                        dvs_d     = divisor_mag;
                        neg_quo_d = signed_i & (dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1]);
                        neg_rem_d = signed_i & dividend_i[WIDTH-1];
                        cnt_d     = '0;
                        state_d   = DIV_BUSY;
                    end
                end
            end
            DIV_BUSY: begin
                if (annul_i) begin
                    state_d = DIV_IDLE;
                end else begin
                    dq_d  = dq_step;
                    rem_d = rem_step;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        // Sign correction applied once, on the final step.
                        // MIN / -1 falls out naturally: |MIN| negated is MIN.
                        lo_d    = neg_quo_q ? -dq_step  : dq_step;
                        hi_d    = neg_rem_q ? -rem_step : rem_step;
                        state_d = DIV_DONE;
                    end
                end
            end
            DIV_DONE: begin
                state_d = DIV_IDLE;
            end
            default: begin
                state_d = DIV_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= DIV_IDLE;
            cnt_q     <= '0;
            dq_q      <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            lo_q      <= '0;
            hi_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dq_q      <= dq_d;
            rem_q     <= rem_d;
            dvs_q     <= dvs_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            lo_q      <= lo_d;
            hi_q      <= hi_d;
        end
    end

    assign state_o     = state_q;
    assign done_o      = (state_q == DIV_DONE) && !annul_i;
    assign quotient_o  = done_o ? lo_q : '0;
    assign remainder_o = done_o ? hi_q : '0;

endmodule

// File: rtl/ex_iter_unit.sv
// ---------------------------------------------------------------------------
// ex_iter_unit
// Execute stage: single-cycle logic/shift/rotate paths plus an iterative
// DIV/DIVU divider with pipeline stall request.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset; all outputs forced to 0 while high
//   bus  : ex_iter_unit_if.slave carrying decode inputs (aluop_i, alusel_i,
//          reg1_i, reg2_i, wd_i, wreg_i, annul_i) and results (wd_o, wreg_o,
//          wdata_o, whilo_o, hi_o, lo_o, stallreq_o)
// ---------------------------------------------------------------------------
module ex_iter_unit
    import ex_iter_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic            clk,
    input  logic            rst,
    ex_iter_unit_if.slave   bus
);

    logic [WIDTH-1:0]   logic_res;
    logic [WIDTH-1:0]   shift_res;
    logic [WIDTH-1:0]   alu_res;
    logic [SHW-1:0]     shamt;
    logic [2*WIDTH-1:0] rot_full;
    logic               div_op;
    div_state_e         div_state;
    logic               div_done;
    logic [WIDTH-1:0]   div_quo;
    logic [WIDTH-1:0]   div_rem;
    logic               stall_raw;

    assign shamt  = bus.reg1_i[SHW-1:0];
    assign div_op = is_div_op(bus.aluop_i);

    // Rotating a doubled copy avoids a separate left shift by WIDTH-shamt.
    assign rot_full = {bus.reg2_i, bus.reg2_i} >> shamt;

    always_comb begin
        logic_res = '0;
        unique case (bus.aluop_i)
            EXE_OR_OP:  logic_res = bus.reg1_i | bus.reg2_i;
            EXE_AND_OP: logic_res = bus.reg1_i & bus.reg2_i;
            EXE_NOR_OP: logic_res = ~(bus.reg1_i | bus.reg2_i);
            EXE_XOR_OP: logic_res = bus.reg1_i ^ bus.reg2_i;
            default:    logic_res = '0;
        endcase
    end

    always_comb begin
        shift_res = '0;
        unique case (bus.aluop_i)
            EXE_SLL_OP: shift_res = bus.reg2_i << shamt;
            EXE_SRL_OP: shift_res = bus.reg2_i >> shamt;
            EXE_SRA_OP: shift_res = $signed(bus.reg2_i) >>> shamt;
            EXE_ROR_OP: shift_res = rot_full[WIDTH-1:0];
            default:    shift_res = '0;
        endcase
    end

    always_comb begin
        alu_res = '0;
        unique case (bus.alusel_i)
            EXE_RES_LOGIC: alu_res = logic_res;
            EXE_RES_SHIFT: alu_res = shift_res;
            default:       alu_res = '0;
        endcase
    end

    div_iter #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_div_iter (
        .clk         (clk),
        .rst         (rst),
        .start_i     (div_op),
        .annul_i     (bus.annul_i),
        .signed_i    (bus.aluop_i == EXE_DIV_OP),
        .dividend_i  (bus.reg1_i),
        .divisor_i   (bus.reg2_i),
        .state_o     (div_state),
        .done_o      (div_done),
        .quotient_o  (div_quo),
        .remainder_o (div_rem)
    );

    // Hold upstream on the arrival cycle (even for divide-by-zero) and
    // throughout BUSY; a flush releases the stall immediately.
    assign stall_raw = !bus.annul_i &&
                       (((div_state == DIV_IDLE) && div_op) || (div_state == DIV_BUSY));

    assign bus.wd_o       = rst ? 5'd0 : bus.wd_i;
    assign bus.wreg_o     = !rst && bus.wreg_i && !div_op;
    assign bus.wdata_o    = rst ? '0 : alu_res;
    assign bus.whilo_o    = !rst && div_done;
    assign bus.lo_o       = rst ? '0 : div_quo;
    assign bus.hi_o       = rst ? '0 : div_rem;
    assign bus.stallreq_o = !rst && stall_raw;

endmodule

// File: doc/ex_iter_unit.md
EX_ITER_UNIT -- requirements
Module: ex_iter_unit

Interface
REQ-001 Parameter WIDTH, default 32: datapath width in bits; legal values are 16, 32 and 64.
REQ-002 Parameter SHW, default $clog2(WIDTH): shift-amount field width.
REQ-003 Port clk, input, 1: rising-edge clock.
REQ-004 Port rst, input, 1: reset, synchronous, active-high.
REQ-005 Port aluop_i, input, 8: operation code from decode.
REQ-006 Port alusel_i, input, 3: result class from decode.
REQ-007 Port reg1_i / reg2_i, input, WIDTH: operands (reg1 = shift amount or dividend; reg2 = shift source or divisor).
REQ-008 Port wd_i, input, 5 / wreg_i, input, 1: destination register address and write enable.
REQ-009 Port annul_i, input, 1: pipeline flush that cancels an in-flight divide.
REQ-010 Ports wd_o (5), wreg_o (1), wdata_o (WIDTH), outputs: GPR writeback.
REQ-011 Ports whilo_o (1), hi_o (WIDTH), lo_o (WIDTH), outputs: HI/LO write strobe and data.
REQ-012 Port stallreq_o, output, 1: request that upstream stages hold their state.

Function
REQ-013 Single-cycle ops, combinational: OR, AND, NOR, XOR, SLL, SRL, SRA and ROR (rotate right).
- Shift amount = reg1_i[SHW-1:0].
- SRA sign-fills from reg2_i[WIDTH-1].
REQ-014 wdata_o: logic result when alusel = RES_LOGIC, shift result when RES_SHIFT, else 0.
REQ-015 wd_o = wd_i.
REQ-016 wreg_o = wreg_i, except wreg_o = 0 for DIV/DIVU.
REQ-017 DIV (signed) and DIVU (unsigned) use a restoring radix-2 divider: one quotient bit per cycle.
REQ-018 Divider FSM states: IDLE, BUSY, DONE.
REQ-019 IDLE -> BUSY when a DIV/DIVU op is present, divisor != 0 and annul_i = 0.
- Operands are latched: magnitudes for DIV; result-sign flags are recorded.
REQ-020 IDLE -> DONE directly when divisor = 0; the result is lo = all ones and hi = dividend.
REQ-021 BUSY lasts exactly WIDTH cycles, counted by a SHW+1-bit counter, then -> DONE.
REQ-022 DONE lasts one cycle: whilo_o = 1, lo_o = quotient, hi_o = remainder; then -> IDLE unconditionally (no restart on the same still-present op).
REQ-023 Signed result correction:
- Quotient is negated when the operand signs differ.
- Remainder takes the sign of the dividend.
- MIN/-1 yields lo = MIN, hi = 0.
REQ-024 stallreq_o = 1 in the op's arrival cycle in IDLE (divide op present, not annulled) and in every BUSY cycle; 0 in DONE and otherwise.
- Latency from op arrival to whilo_o: WIDTH+2 cycles (2 cycles for divide-by-zero).
REQ-025 annul_i = 1 in BUSY or DONE -> next state IDLE, whilo_o forced to 0 in that cycle, and stallreq_o = 0 in that cycle.
REQ-026 whilo_o = 0, and hi_o/lo_o = 0, in every non-DONE cycle.

Reset
REQ-027 rst = 1 at a clock edge forces IDLE and clears the counter, operand and result registers; a divide in progress is abandoned.
REQ-028 While rst = 1, all outputs are 0, including wdata_o, wreg_o, whilo_o and stallreq_o.

Structure
REQ-029 A shared package holds the opcode constants (EXE_*_OP, including ROR, DIV, DIVU), the alusel constants (EXE_RES_*) and the FSM state enum.
REQ-030 The divider is the sub-module div_iter: start, annul, signed flag, operands in; done, quotient, remainder out.
- ex_iter_unit contains the single-cycle logic/shift paths, the result mux and the stall logic.

Verification
REQ-031 WIDTH=32, SRA: reg2 = 0x80000010, amt = 4 -> wdata_o = 0xF8000001. ROR: reg2 = 0x00000001, amt = 1 -> wdata_o = 0x80000000.
REQ-032 DIVU 100/7 -> stallreq_o high for 33 cycles; in the 34th cycle whilo_o = 1, lo_o = 14, hi_o = 2.
REQ-033 DIV -7/2 -> lo_o = 0xFFFFFFFD (-3), hi_o = 0xFFFFFFFF (-1). DIV 0x80000000 / 0xFFFFFFFF -> lo_o = 0x80000000, hi_o = 0.
REQ-034 DIV 5/0 -> stallreq_o high for 1 cycle; next cycle whilo_o = 1, lo_o = 0xFFFFFFFF, hi_o = 5.
REQ-035 annul_i pulsed in BUSY cycle 10 -> stallreq_o low that cycle, no whilo_o pulse; a following DIVU 9/3 gives lo_o = 3, hi_o = 0. Repeat with rst instead of annul_i: same recovery.
REQ-036 WIDTH=16 regression: DIVU 0xFFFF/0x0010 -> lo_o = 0x0FFF, hi_o = 0x000F after 18 cycles.
